// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the accumulator ALU execute path.
// Opcode encodings, default widths and sequencer states.
package alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   localparam logic [2:0] OP_ADD     = 3'd0;
   localparam logic [2:0] OP_SHL     = 3'd1;
   localparam logic [2:0] OP_XNOR    = 3'd2;
   localparam logic [2:0] OP_SHR     = 3'd3;
   localparam logic [2:0] OP_LOAD    = 3'd4;
   localparam logic [2:0] OP_STORE   = 3'd5;
   localparam logic [2:0] OP_NEG     = 3'd6;
   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_SETTLE = 3'd3,
      S_WB     = 3'd4,
      S_STORE  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Data memory request port of the execute sequencer.
// master = sequencer, slave = memory.
interface alu_exec_ctrl_if
   import alu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready
   );

endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer for the accumulator ALU.
// Owns AC/DR/E, fetches operands and writes back results.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        opcode,
   input  logic [ADDR_W-1:0] addr,
   alu_exec_ctrl_if.master   mem,
   output logic [2:0]        alu_mode,
   output logic              alu_activate,
   output logic [DATA_W-1:0] alu_ac,
   output logic [DATA_W-1:0] alu_dr,
   input  logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] ac,
   output logic              e,
   output logic              busy,
   output logic              done,
   output logic              illegal
);

   state_t            state;
   logic [DATA_W-1:0] ac_q;
   logic [DATA_W-1:0] dr_q;
   logic              e_q;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        mode_q;
   logic              act_q;
   logic              busy_q;
   logic              done_q;
   logic              ill_q;

   // carry-out for ADD comes from one zero-extended add
   logic [DATA_W:0]   sum;
   assign sum = {1'b0, ac_q} + {1'b0, dr_q};

   // sequencer: every output is a register written here
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ac_q    <= '0;
         dr_q    <= '0;
         e_q     <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mode_q  <= 3'd0;
         act_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ill_q  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q <= opcode;
                  addr_q <= addr;
                  busy_q <= 1'b1;
                  unique case (1'b1)
                     (opcode == OP_STORE): begin
                        state   <= S_STORE;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        wdata_q <= ac_q;
                     end
                     (opcode == OP_ILLEGAL): begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        ill_q  <= 1'b1;
                     end
                     default: begin
                        state <= S_FETCH;
                        req_q <= 1'b1;
                        we_q  <= 1'b0;
                     end
                  endcase
               end
            end
            S_FETCH: begin
               if (mem.mem_ready) begin
                  dr_q  <= mem.mem_rdata;
                  req_q <= 1'b0;
                  act_q <= 1'b1;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               act_q <= 1'b0;
               state <= S_SETTLE;
            end
            S_SETTLE: begin
               state <= S_WB;
            end
            S_WB: begin
               ac_q <= alu_result;
               unique case (1'b1)
                  (mode_q == OP_ADD): e_q <= sum[DATA_W];
                  (mode_q == OP_SHL): e_q <= dr_q[DATA_W-1];
                  default:            e_q <= e_q;
               endcase
               done_q <= 1'b1;
               state  <= S_DONE;
            end
            S_STORE: begin
               if (mem.mem_ready) begin
                  req_q  <= 1'b0;
                  we_q   <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   assign alu_mode     = mode_q;
   assign alu_activate = act_q;
   assign alu_ac       = ac_q;
   assign alu_dr       = dr_q;
   assign ac           = ac_q;
   assign e            = e_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with an ALU and memory model.
// Expected results are pushed at issue and checked on done.
module tb_alu_exec_ctrl;
   import alu_pkg::*;

   typedef struct {
      logic [7:0] ac;
      logic       e;
      logic       ill;
      int         cyc;
      int         act;
      int         req;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] opcode;
   logic [7:0] addr;
   logic [2:0] alu_mode;
   logic       alu_activate;
   logic [7:0] alu_ac;
   logic [7:0] alu_dr;
   logic [7:0] alu_result;
   logic [7:0] ac;
   logic       e;
   logic       busy;
   logic       done;
   logic       illegal;

   alu_exec_ctrl_if #(.ADDR_W(8), .DATA_W(8)) mif ();

   alu_exec_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .opcode       (opcode),
      .addr         (addr),
      .mem          (mif),
      .alu_mode     (alu_mode),
      .alu_activate (alu_activate),
      .alu_ac       (alu_ac),
      .alu_dr       (alu_dr),
      .alu_result   (alu_result),
      .ac           (ac),
      .e            (e),
      .busy         (busy),
      .done         (done),
      .illegal      (illegal)
   );

   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         act_cnt = 0;
   int         req_cnt = 0;
   int         stab_err = 0;
   int         stall_cfg = 0;
   int         wait_cnt = 0;
   int         wr_cnt = 0;
   logic [7:0] wr_addr = 8'h00;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] mem [256];

   logic       p_req = 1'b0;
   logic       p_we = 1'b0;
   logic [7:0] p_addr = 8'h00;
   logic [7:0] p_wdata = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // memory: ready after stall_cfg low cycles
   assign mif.mem_ready = mif.mem_req && (wait_cnt >= stall_cfg);
   assign mif.mem_rdata = mem[mif.mem_addr];

   always @(posedge clk) begin
      if (mif.mem_req && !mif.mem_ready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (mif.mem_req && mif.mem_ready && mif.mem_we) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= mif.mem_addr;
         wr_data <= mif.mem_wdata;
      end
   end

   // ALU model: captures on rising activate
   initial alu_result = 8'h00;
   always @(posedge alu_activate) begin
      #1;
      case (alu_mode)
         3'd0:    alu_result = alu_ac + alu_dr;
         3'd1:    alu_result = alu_dr << 1;
         3'd2:    alu_result = ~(alu_ac ^ alu_dr);
         3'd3:    alu_result = alu_dr >> 1;
         3'd4:    alu_result = alu_dr;
         3'd6:    alu_result = 8'h00 - alu_dr;
         default: alu_result = alu_ac;
      endcase
   end

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // monitor: counts pulses, checks stability, pops on done
   always @(negedge clk) begin
      exp_t x;
      if (alu_activate) act_cnt++;
      if (mif.mem_req) req_cnt++;
      if (mif.mem_req && p_req &&
          (mif.mem_addr != p_addr || mif.mem_we != p_we ||
           (mif.mem_we && mif.mem_wdata != p_wdata)))
         stab_err++;
      p_req   = mif.mem_req;
      p_we    = mif.mem_we;
      p_addr  = mif.mem_addr;
      p_wdata = mif.mem_wdata;
      if (illegal && !done) chk("illegal_without_done", 1, 0);
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            x = sb.pop_front();
            chk("ac", int'(ac), int'(x.ac));
            chk("e", int'(e), int'(x.e));
            chk("illegal", int'(illegal), int'(x.ill));
            chk("done_cycle", cyc, x.cyc);
            chk("activate_cycles", act_cnt, x.act);
            chk("req_cycles", req_cnt, x.req);
         end
      end
   end

   task automatic run_op(logic [2:0] op, logic [7:0] a, int stall,
                         logic [7:0] eac, logic ee, bit poke);
      exp_t x;
      int   lat;
      int   nact;
      int   nreq;
      @(negedge clk);
      stall_cfg = stall;
      if (op == 3'd7) begin
         lat = 1; nact = 0; nreq = 0;
      end else if (op == 3'd5) begin
         lat = 2 + stall; nact = 0; nreq = 1 + stall;
      end else begin
         lat = 5 + stall; nact = 1; nreq = 1 + stall;
      end
      x.ac  = eac;
      x.e   = ee;
      x.ill = (op == 3'd7);
      x.cyc = cyc + lat;
      x.act = act_cnt + nact;
      x.req = req_cnt + nreq;
      sb.push_back(x);
      start  = 1'b1;
      opcode = op;
      addr   = a;
      @(negedge clk);
      start  = 1'b0;
      opcode = 3'd0;
      addr   = 8'hFF;
      if (poke) begin
         start  = 1'b1;
         opcode = 3'd7;
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 60 && busy; i++) @(negedge clk);
      chk("op_timeout", int'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h3C;
      mem[8'h11] = 8'hF0;
      mem[8'h12] = 8'h20;
      mem[8'h13] = 8'h81;
      mem[8'h14] = 8'h0F;
      mem[8'h15] = 8'h01;
      mem[8'h16] = 8'hA5;
      rst_n  = 1'b0;
      start  = 1'b0;
      opcode = 3'd0;
      addr   = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_ac", int'(ac), 0);
      chk("rst_e", int'(e), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_mem_req", int'(mif.mem_req), 0);
      chk("rst_mem_we", int'(mif.mem_we), 0);
      chk("rst_activate", int'(alu_activate), 0);

      run_op(3'd4, 8'h10, 0, 8'h3C, 1'b0, 1'b0);
      run_op(3'd4, 8'h11, 0, 8'hF0, 1'b0, 1'b0);
      run_op(3'd0, 8'h12, 0, 8'h10, 1'b1, 1'b0);
      run_op(3'd1, 8'h13, 0, 8'h02, 1'b1, 1'b0);
      run_op(3'd4, 8'h10, 0, 8'h3C, 1'b1, 1'b0);
      run_op(3'd2, 8'h14, 0, 8'hCC, 1'b1, 1'b1);
      run_op(3'd6, 8'h15, 0, 8'hFF, 1'b1, 1'b0);
      run_op(3'd3, 8'h13, 2, 8'h40, 1'b1, 1'b0);
      run_op(3'd4, 8'h16, 0, 8'hA5, 1'b1, 1'b0);

      run_op(3'd5, 8'h22, 3, 8'hA5, 1'b1, 1'b0);
      chk("store_wr_count", wr_cnt, 1);
      chk("store_wr_addr", int'(wr_addr), 8'h22);
      chk("store_wr_data", int'(wr_data), 8'hA5);

      run_op(3'd7, 8'h30, 0, 8'hA5, 1'b1, 1'b0);
      chk("illegal_no_write", wr_cnt, 1);

      @(negedge clk);
      stall_cfg = 100;
      start  = 1'b1;
      opcode = 3'd4;
      addr   = 8'h10;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("fetch_req_held", int'(mif.mem_req), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stall_cfg = 0;
      chk("abort_mem_req", int'(mif.mem_req), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_ac", int'(ac), 0);
      chk("abort_e", int'(e), 0);

      run_op(3'd4, 8'h10, 0, 8'h3C, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      chk("req_stability", stab_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
